// File: rtl/stream_frame_pkg.sv
// Shared types and defaults for the stream frame checker and its helpers.
// Frame format on the wire: SYNC, LEN, LEN payload bytes, CSUM (8-bit sum of LEN and payload).
package stream_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_LEN_DEFAULT   = 16;
  localparam int         TIMEOUT_DEFAULT   = 32;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic len_legal(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && ({24'd0, len} <= max_len);
  endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Counts consecutive idle cycles while a frame is open; flags the cycle in
// which the TIMEOUT-th idle cycle is seen so the FSM can abort on that edge.
module frame_timeout_timer
  import stream_frame_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    // NOTE: assign every comb output a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_W'(TIMEOUT))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (count_q == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stream_frame_checker.sv
// Framed byte-stream checker: hunts for SYNC, validates length, forwards the
// payload one cycle late, verifies the checksum and keeps good/error counters.
module stream_frame_checker
  import stream_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN   = MAX_LEN_DEFAULT,
  parameter int         TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] frame_count,
  output logic [7:0] err_count
);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [7:0] err_count_q, err_count_d;

  logic timer_enable;
  logic timer_clear;
  logic timed_out;
  logic len_ok;

  // The timer only runs while a frame is open and no byte arrives.
  assign timer_enable = (state_q != ST_IDLE) && !in_valid;
  assign timer_clear  = (state_q == ST_IDLE) || in_valid;
  assign len_ok       = len_legal(in_data, MAX_LEN);

  frame_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (timer_enable),
    .clear   (timer_clear),
    .expired (timed_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A SYNC byte inside a frame is ordinary data; only IDLE looks for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_data == SYNC_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (timed_out)     state_d = ST_IDLE;
        else if (in_valid) state_d = len_ok ? ST_PAYLOAD : ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (timed_out)                                state_d = ST_IDLE;
        else if (in_valid && (remaining_q == 8'd1))   state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (timed_out || in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d         = len_q;
    remaining_d   = remaining_q;
    csum_d        = csum_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    out_last_d    = 1'b0;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      ST_LEN: begin
        if (in_valid) begin
          len_d  = in_data;
          csum_d = in_data;
          if (len_ok) remaining_d = in_data;
          else        frame_err_d = 1'b1;
        end else if (timed_out) begin
          frame_err_d = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          csum_d      = csum_add(csum_q, in_data);
          remaining_d = remaining_q - 8'd1;
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_last_d  = (remaining_q == 8'd1);
        end else if (timed_out) begin
          frame_err_d = 1'b1;
        end
      end
      ST_CSUM: begin
        if (in_valid) begin
          if (in_data == csum_q) frame_ok_d  = 1'b1;
          else                   frame_err_d = 1'b1;
        end else if (timed_out) begin
          frame_err_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (frame_ok_d) frame_count_d = frame_count_q + 8'd1;
    if (frame_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= '0;
      remaining_q   <= '0;
      csum_q        <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      len_q         <= len_d;
      remaining_q   <= remaining_d;
      csum_q        <= csum_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // The latched length is debug state only; the decrementing counter drives the logic.
  logic len_unused;
  assign len_unused = ^len_q;

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_stream_frame_checker.sv
// Scoreboard bench: a frame-level reference model queues expected payload
// bytes and status pulses; a negedge monitor pops and compares them.
module tb_stream_frame_checker;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 32;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } data_exp_t;

  typedef struct {
    logic       is_ok;
    logic [7:0] fc;
    logic [7:0] ec;
    int         cyc;
  } status_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_valid, out_last, frame_ok, frame_err;
  logic [7:0] out_data, frame_count, err_count;

  always #5 clk = ~clk;

  stream_frame_checker #(
    .SYNC_BYTE (SYNC),
    .MAX_LEN   (MAX_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  data_exp_t   exp_data[$];
  status_exp_t exp_status[$];

  // Reference model: phase 0 hunt, 1 length, 2 body, 3 checksum.
  int         m_phase = 0;
  int         m_len = 0;
  int         m_idle = 0;
  int         m_fc = 0;
  int         m_ec = 0;
  logic [7:0] m_body[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] frame_sum();
    int s = m_len;
    foreach (m_body[i]) s += int'(m_body[i]);
    return 8'(s % 256);
  endfunction

  task automatic push_status(input logic ok);
    status_exp_t s;
    if (ok) m_fc = (m_fc + 1) % 256;
    else if (m_ec < 255) m_ec++;
    s.is_ok = ok;
    s.fc    = 8'(m_fc);
    s.ec    = 8'(m_ec);
    s.cyc   = cyc + 1;
    exp_status.push_back(s);
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] d);
    data_exp_t e;
    if (m_phase == 0) begin
      m_idle = 0;
      if (v && d == SYNC) m_phase = 1;
    end else if (!v) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        push_status(1'b0);
        m_phase = 0;
        m_idle  = 0;
      end
    end else begin
      m_idle = 0;
      case (m_phase)
        1: begin
          if (d == 8'd0 || int'(d) > MAX_LEN) begin
            push_status(1'b0);
            m_phase = 0;
          end else begin
            m_len = int'(d);
            m_body.delete();
            m_phase = 2;
          end
        end
        2: begin
          m_body.push_back(d);
          e.data = d;
          e.last = (m_body.size() == m_len);
          e.cyc  = cyc + 1;
          exp_data.push_back(e);
          if (m_body.size() == m_len) m_phase = 3;
        end
        3: begin
          push_status(d == frame_sum());
          m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_idle  = 0;
    m_fc    = 0;
    m_ec    = 0;
    m_body.delete();
    exp_data.delete();
    exp_status.delete();
  endtask

  // Called at posedge+1; the byte is consumed at the next rising edge.
  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    model_cycle(v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic send(input logic [7:0] seq[$], input bit gappy);
    foreach (seq[i]) begin
      if (gappy && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      drive(1'b1, seq[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic build_frame(output logic [7:0] seq[$], input int len, input bit bad_csum);
    logic [7:0] sum;
    seq.delete();
    seq.push_back(SYNC);
    seq.push_back(8'(len));
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      seq.push_back(b);
      sum = sum + b;
    end
    if (bad_csum) sum = sum ^ 8'($urandom_range(1, 255));
    seq.push_back(sum);
  endtask

  data_exp_t   mon_d;
  status_exp_t mon_s;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_data.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_d = exp_data.pop_front();
          check("out_data", 32'(out_data), 32'(mon_d.data));
          check("out_last", 32'(out_last), 32'(mon_d.last));
          check("out_cycle", 32'(cyc), 32'(mon_d.cyc));
        end
      end else if (out_last) begin
        check("out_last_without_valid", 32'(out_last), 32'd0);
      end
      if (frame_ok && frame_err) begin
        check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
      end else if (frame_ok || frame_err) begin
        if (exp_status.size() == 0) begin
          check("unexpected_status", {30'd0, frame_ok, frame_err}, 32'd0);
        end else begin
          mon_s = exp_status.pop_front();
          check("status_ok", 32'(frame_ok), 32'(mon_s.is_ok));
          check("status_err", 32'(frame_err), 32'(!mon_s.is_ok));
          check("status_frame_count", 32'(frame_count), 32'(mon_s.fc));
          check("status_err_count", 32'(err_count), 32'(mon_s.ec));
          check("status_cycle", 32'(cyc), 32'(mon_s.cyc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] seq[$];

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    apply_reset();

    // Good frame, back-to-back.
    seq = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    send(seq, 1'b0);
    idle(3);
    check("good_frame_count", 32'(frame_count), 32'd1);
    check("good_err_count", 32'(err_count), 32'd0);

    // Bad checksum.
    apply_reset();
    seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send(seq, 1'b0);
    idle(3);
    check("bad_csum_err_count", 32'(err_count), 32'd1);
    check("bad_csum_frame_count", 32'(frame_count), 32'd0);

    // Illegal lengths: zero and MAX_LEN+1.
    apply_reset();
    seq = '{8'hA5, 8'h00};
    send(seq, 1'b0);
    idle(2);
    seq = '{8'hA5, 8'h11};
    send(seq, 1'b0);
    idle(3);
    check("bad_len_err_count", 32'(err_count), 32'd2);

    // Leading garbage, SYNC value as payload.
    apply_reset();
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'hA6};
    send(seq, 1'b0);
    idle(3);
    check("sync_payload_frame_count", 32'(frame_count), 32'd1);

    // Timeout inside a frame, then recovery.
    apply_reset();
    seq = '{8'hA5, 8'h04, 8'h11};
    send(seq, 1'b0);
    idle(TIMEOUT);
    idle(2);
    check("timeout_err_count", 32'(err_count), 32'd1);
    seq = '{8'hA5, 8'h01, 8'h07, 8'h08};
    send(seq, 1'b0);
    idle(3);
    check("after_timeout_frame_count", 32'(frame_count), 32'd1);

    // Reset mid-payload.
    apply_reset();
    seq = '{8'hA5, 8'h01, 8'h07, 8'h08, 8'hA5, 8'h04, 8'h11, 8'h22};
    send(seq, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'd0);
    check("midreset_out_last", 32'(out_last), 32'd0);
    check("midreset_status", {30'd0, frame_ok, frame_err}, 32'd0);
    check("midreset_frame_count", 32'(frame_count), 32'd0);
    check("midreset_err_count", 32'(err_count), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h79};
    send(seq, 1'b0);
    idle(3);
    check("post_reset_frame_count", 32'(frame_count), 32'd1);
    check("post_reset_err_count", 32'(err_count), 32'd0);

    // Randomized mix of frames, gaps, errors and timeouts.
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          seq.delete();
          for (int j = 0; j < $urandom_range(1, 3); j++) seq.push_back(8'($urandom_range(0, 255)));
          send(seq, 1'b0);
        end
        2, 3, 4, 5: begin
          build_frame(seq, $urandom_range(1, MAX_LEN), 1'b0);
          send(seq, 1'b1);
        end
        6: begin
          build_frame(seq, $urandom_range(1, MAX_LEN), 1'b1);
          send(seq, 1'b1);
        end
        7: begin
          seq = '{SYNC, 8'h00};
          seq[1] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
          send(seq, 1'b1);
        end
        8: begin
          build_frame(seq, $urandom_range(2, MAX_LEN), 1'b0);
          seq = seq[0:$urandom_range(1, 3)];
          send(seq, 1'b0);
          idle(TIMEOUT + 1);
        end
        default: idle($urandom_range(0, 5));
      endcase
    end
    idle(TIMEOUT + 4);
    check("random_frame_count", 32'(frame_count), 32'(m_fc));
    check("random_err_count", 32'(err_count), 32'(m_ec));

    // frame_count wraps after 256 good frames; err_count saturates at 255.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      build_frame(seq, 1, 1'b0);
      send(seq, 1'b0);
    end
    idle(3);
    check("frame_count_wrap", 32'(frame_count), 32'd0);
    for (int i = 0; i < 260; i++) begin
      seq = '{SYNC, 8'h00};
      send(seq, 1'b0);
    end
    idle(3);
    check("err_count_saturate", 32'(err_count), 32'd255);

    idle(4);
    check("exp_data_drained", 32'(exp_data.size()), 32'd0);
    check("exp_status_drained", 32'(exp_status.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
